// File: rtl/cpu_step_ctrl_pkg.sv
// Shared encodings for the cpu execution-rate controller.
package cpu_step_ctrl_pkg;

  localparam int DIV_SEL_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_BRK  = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// Pushbutton conditioning: 2-flop synchronizer, stable-sample counter and a
// one-cycle pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic step_evt
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync_1;
  logic             sync_2;
  logic             level;
  logic [CNT_W-1:0] stable_cnt;

  // Synchronize, then accept a new level only after DEB_CYCLES differing samples in a row
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
      step_evt   <= 1'b0;
    end else begin
      sync_1   <= btn;
      sync_2   <= sync_1;
      step_evt <= 1'b0;
      if (sync_2 != level) begin
        if (stable_cnt == CNT_W'(DEB_CYCLES - 1)) begin
          level      <= sync_2;
          stable_cnt <= '0;
          step_evt   <= sync_2;
        end else begin
          stable_cnt <= stable_cnt + CNT_W'(1);
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Clock-enable generator for the single-cycle cpu: free-run, single-step and
// an optional PC breakpoint (compiled in with `define BREAKPOINT_EN).
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int DIV_W      = 24,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int PC_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_req,
  input  logic                 step_btn,
  input  logic [DIV_SEL_W-1:0] div_sel,
  input  logic [PC_W-1:0]      pc,
  input  logic [PC_W-1:0]      bp_addr,
  input  logic                 bp_arm,
  output logic                 cpu_ce,
  output logic                 halted,
  output logic [1:0]           state,
  output logic [31:0]          step_count
);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic               ce_d;
  logic               skip_q, skip_d;
  logic               block_q, block_d;
  logic               step_evt;
  logic               tick;
  logic               bp_hit;
  logic [DIV_SEL_W-1:0] sel_eff;
  logic [DIV_W:0]     period_m1;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk      (clk),
    .reset    (reset),
    .btn      (step_btn),
    .step_evt (step_evt)
  );

  assign sel_eff   = (div_sel > DIV_SEL_W'(DIV_W)) ? DIV_SEL_W'(DIV_W) : div_sel;
  assign period_m1 = ((DIV_W+1)'(1) << sel_eff) - (DIV_W+1)'(1);
  // >= rather than == so a lowered div_sel ticks on the very next cycle
  assign tick      = {1'b0, presc_q} >= period_m1;

`ifdef BREAKPOINT_EN
  assign bp_hit = bp_arm && (pc == bp_addr) && !skip_q;
`else
  logic unused_bp;
  assign unused_bp = ^{pc, bp_addr, bp_arm, skip_q};
  assign bp_hit    = 1'b0;
`endif

  // Next-state, prescaler and pulse decision
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    ce_d    = 1'b0;
    skip_d  = skip_q;
    // block holds off free-run after a breakpoint until run_req has been dropped
    block_d = block_q & run_req;
    case (state_q)
      ST_IDLE: begin
        if (run_req && !block_q) begin
          state_d = ST_RUN;
          presc_d = '0;
          skip_d  = 1'b1;
        end else if (step_evt) begin
          state_d = ST_STEP;
          ce_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: state_d = ST_IDLE;
      ST_RUN: begin
        if (!run_req) begin
          state_d = ST_IDLE;
          presc_d = '0;
        end else if (tick) begin
          presc_d = '0;
          if (bp_hit) begin
            state_d = ST_BRK;
            block_d = 1'b1;
          end else begin
            ce_d   = 1'b1;
            skip_d = 1'b0;
          end
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
      ST_BRK: begin
        if (step_evt) begin
          state_d = ST_STEP;
          ce_d    = 1'b1;
        end else if (!run_req) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BRK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, registered outputs and pulse counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      cpu_ce     <= 1'b0;
      halted     <= 1'b1;
      skip_q     <= 1'b1;
      block_q    <= 1'b0;
      step_count <= 32'd0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cpu_ce  <= ce_d;
      halted  <= (state_d == ST_IDLE) || (state_d == ST_BRK);
      skip_q  <= skip_d;
      block_q <= block_d;
      if (cpu_ce) begin
        step_count <= step_count + 32'd1;
      end
    end
  end

  assign state = state_q;

endmodule
